// File: rtl/xnor_parity_rx_if.sv
// Serial-in / parallel-out bundle for the XNOR parity receiver; master drives stimulus and ready.
interface xnor_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              sin_valid;
  logic              sin_bit;
  logic              sin_sof;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              par_err;
  logic              abort;
  logic              ovf;

  modport master (
    output sin_valid, sin_bit, sin_sof, dout_ready,
    input  dout, dout_valid, par_err, abort, ovf
  );

  modport slave (
    input  sin_valid, sin_bit, sin_sof, dout_ready,
    output dout, dout_valid, par_err, abort, ovf
  );
endinterface

// File: rtl/xnor_parity_rx.sv
// XNOR (odd) parity frame receiver: LSB-first deserialise, dout_valid 1 cycle after parity strobe, held until ready.
// A sof while the word is held is dropped (ovf); XNOR_PARITY_RX_DROP_ERR_EN discards failing frames.
module xnor_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  xnor_parity_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;

  localparam state_t FIRST_ST = (DATA_W == 1) ? PARITY : DATA;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [DATA_W-1:0] dout_r, dout_nxt;
  logic              vld, vld_nxt;
  logic              perr, perr_nxt;
  logic              abort_r, abort_nxt;
  logic              ovf_r, ovf_nxt;
  logic              sof_stb, bit_stb, p_err;

  assign sof_stb = bus.sin_valid & bus.sin_sof;
  assign bit_stb = bus.sin_valid & ~bus.sin_sof;
  // Valid frame has odd ones across data plus parity.
  assign p_err   = ~(^sreg ^ bus.sin_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      dout_r  <= '0;
      vld     <= 1'b0;
      perr    <= 1'b0;
      abort_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sreg    <= sreg_nxt;
      dout_r  <= dout_nxt;
      vld     <= vld_nxt;
      perr    <= perr_nxt;
      abort_r <= abort_nxt;
      ovf_r   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    dout_nxt  = dout_r;
    vld_nxt   = vld;
    perr_nxt  = (state == HOLD) ? perr : 1'b0;
    abort_nxt = 1'b0;
    ovf_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (sof_stb) begin
          sreg_nxt  = DATA_W'(bus.sin_bit);
          cnt_nxt   = CW'(1);
          state_nxt = FIRST_ST;
        end
      end
      DATA: begin
        if (sof_stb) begin
          abort_nxt = 1'b1;
          sreg_nxt  = DATA_W'(bus.sin_bit);
          cnt_nxt   = CW'(1);
          state_nxt = FIRST_ST;
        end else if (bit_stb) begin
          sreg_nxt = sreg | (DATA_W'(bus.sin_bit) << cnt);
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1))
            state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (sof_stb) begin
          abort_nxt = 1'b1;
          sreg_nxt  = DATA_W'(bus.sin_bit);
          cnt_nxt   = CW'(1);
          state_nxt = FIRST_ST;
        end else if (bit_stb) begin
          dout_nxt  = sreg;
          vld_nxt   = 1'b1;
          perr_nxt  = p_err;
          cnt_nxt   = '0;
          state_nxt = HOLD;
`ifdef XNOR_PARITY_RX_DROP_ERR_EN
          // Failing frame: report via one-cycle par_err, keep previous word.
          if (p_err) begin
            dout_nxt  = dout_r;
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
`endif
        end
      end
      HOLD: begin
        if (bus.dout_ready) begin
          vld_nxt  = 1'b0;
          perr_nxt = 1'b0;
          if (sof_stb) begin
            sreg_nxt  = DATA_W'(bus.sin_bit);
            cnt_nxt   = CW'(1);
            state_nxt = FIRST_ST;
          end else begin
            state_nxt = IDLE;
          end
        end else if (sof_stb) begin
          ovf_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = vld;
  assign bus.par_err    = perr;
  assign bus.abort      = abort_r;
  assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_xnor_parity_rx.sv
// Directed bench for xnor_parity_rx with a scoreboard of expected words checked at each handshake.
module tb_xnor_parity_rx;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n_abort = 0;
  int   n_ovf = 0;
  int   n_both = 0;
  logic [DATA_W:0] sb[$];

  xnor_parity_rx_if #(.DATA_W(DATA_W)) bus ();

  xnor_parity_rx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity model: frame is good when total ones (data plus p) is odd.
  function automatic logic model_err(input logic [DATA_W-1:0] d, input logic p);
    int ones = int'(p);
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic drive(input logic v, input logic b, input logic s);
    @(posedge clk);
    #1;
    bus.sin_valid = v;
    bus.sin_bit   = b;
    bus.sin_sof   = s;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.dout_ready = r;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic rdy_at_sof);
    logic err;
    err = model_err(d, p);
`ifdef XNOR_PARITY_RX_DROP_ERR_EN
    if (!err) sb.push_back({err, d});
`else
    sb.push_back({err, d});
`endif
    @(posedge clk);
    #1;
    bus.sin_valid = 1'b1;
    bus.sin_bit   = d[0];
    bus.sin_sof   = 1'b1;
    if (rdy_at_sof) bus.dout_ready = 1'b1;
    for (int i = 1; i < DATA_W; i++) drive(1'b1, d[i], 1'b0);
    drive(1'b1, p, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (bus.abort) n_abort++;
    if (bus.ovf) n_ovf++;
    if (bus.abort && bus.ovf) n_both++;
  end

  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed word %0h with no expected entry", bus.dout);
      end else begin
        logic [DATA_W:0] e;
        e = sb.pop_front();
        chk("sb_dout", 32'(bus.dout), 32'(e[DATA_W-1:0]));
        chk("sb_par_err", 32'(bus.par_err), 32'(e[DATA_W]));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, o0;
    rst_n          = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.sin_bit    = 1'b0;
    bus.sin_sof    = 1'b0;
    bus.dout_ready = 1'b0;
    #12;
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_par_err", 32'(bus.par_err), 0);
    chk("rst_abort", 32'(bus.abort), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.dout_ready = 1'b1;

    // Good frame, consumer always ready
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    chk("a5_valid", 32'(bus.dout_valid), 1);
    chk("a5_dout", 32'(bus.dout), 32'h A5);
    chk("a5_par_err", 32'(bus.par_err), 0);
    @(negedge clk);
    chk("a5_valid_drop", 32'(bus.dout_valid), 0);

    // Wrong parity
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
`ifdef XNOR_PARITY_RX_DROP_ERR_EN
    chk("e07_no_valid", 32'(bus.dout_valid), 0);
    chk("e07_par_err_pulse", 32'(bus.par_err), 1);
    @(negedge clk);
    chk("e07_par_err_clear", 32'(bus.par_err), 0);
    chk("e07_dout_kept", 32'(bus.dout), 32'h A5);
`else
    chk("e07_valid", 32'(bus.dout_valid), 1);
    chk("e07_par_err", 32'(bus.par_err), 1);
    @(negedge clk);
    chk("e07_valid_drop", 32'(bus.dout_valid), 0);
    chk("e07_par_err_clear", 32'(bus.par_err), 0);
`endif

    // Held word, new sof overflows
    set_ready(1'b0);
    o0 = n_ovf;
    send_frame(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("ovf_count", 32'(n_ovf - o0), 1);
    chk("hold_valid", 32'(bus.dout_valid), 1);
    chk("hold_dout", 32'(bus.dout), 32'h3C);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("hold_released", 32'(bus.dout_valid), 0);

    // Restart mid-frame
    a0 = n_abort;
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("ff_dout", 32'(bus.dout), 32'hFF);
    chk("ff_par_err", 32'(bus.par_err), 0);
    @(posedge clk);
    #1;
    chk("abort_count", 32'(n_abort - a0), 1);

    // Handshake coincides with next sof
    set_ready(1'b0);
    send_frame(8'h18, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("b2b_hold_valid", 32'(bus.dout_valid), 1);
    o0 = n_ovf;
    send_frame(8'h81, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b_dout", 32'(bus.dout), 32'h81);
    chk("b2b_valid", 32'(bus.dout_valid), 1);
    @(posedge clk);
    #1;
    chk("b2b_no_ovf", 32'(n_ovf - o0), 0);

    // Asynchronous reset mid-frame
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #3;
    rst_n         = 1'b0;
    bus.sin_valid = 1'b0;
    #1;
    chk("arst_dout", 32'(bus.dout), 0);
    chk("arst_valid", 32'(bus.dout_valid), 0);
    chk("arst_par_err", 32'(bus.par_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_dout", 32'(bus.dout), 32'h5A);
    chk("post_rst_valid", 32'(bus.dout_valid), 1);
    chk("post_rst_par_err", 32'(bus.par_err), 0);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    chk("abort_ovf_overlap", 32'(n_both), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xnor_parity_rx.md
Name: xnor_parity_rx

Overview:
- Serial frame receiver and checker: the receiving end of the team's XNOR (odd) parity link.
- The transmitter sends DATA_W data bits LSB-first, then one parity bit equal to the XNOR-reduction of the data, so every valid frame has an odd number of ones.
- The block deserialises each frame, checks parity, and presents the word on a valid/ready parallel output.
- Sits between the serial link pins/strobe logic and the consuming datapath.

Parameters:
DATA_W, 8, data bits per frame (2..32)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sin_valid  input  1  serial bit strobe; sin_bit/sin_sof sampled only when high
sin_bit  input  1  serial data/parity bit
sin_sof  input  1  marks first data bit of a frame (qualified by sin_valid)
dout  output  DATA_W  received data word
dout_valid  output  1  dout/par_err valid; held until accepted
dout_ready  input  1  consumer accepts when dout_valid && dout_ready
par_err  output  1  parity check failed for the word on dout
abort  output  1  one-cycle pulse: frame in progress discarded by a new sof
ovf  output  1  one-cycle pulse: sof dropped because output still held

Behaviour:
- Reset (async, rst_n=0): state IDLE, bit counter 0, shift register 0, dout=0, dout_valid=0, par_err=0, abort=0, ovf=0. Reset mid-frame discards the frame with no pulse.
- States: IDLE, DATA, PARITY, HOLD.
- IDLE: sin_valid&&sin_sof -> capture sin_bit as bit0, cnt=1, go DATA (if DATA_W==1 go PARITY). sin_valid without sof ignored.
- DATA: each sin_valid without sof shifts sin_bit into bit position cnt, cnt++. After bit DATA_W-1 is captured, go PARITY.
- PARITY: next sin_valid without sof = parity bit p. Compute err = ~(^data ^ p), i.e. error unless data+p has odd ones. Load dout=data, par_err=err, dout_valid=1, go HOLD. dout_valid rises the cycle after the parity strobe (1-cycle latency).
- sof in DATA or PARITY: pulse abort, drop partial frame, restart with sin_bit as bit0 (cnt=1, state DATA).
- HOLD: dout, par_err, dout_valid stable until dout_valid&&dout_ready.
  - Handshake with no sof: dout_valid=0, go IDLE. dout holds its last value, par_err clears.
  - Handshake in the same cycle as sin_valid&&sin_sof: the handshake completes, the sof is accepted as bit0, and the state goes DATA.
  - sin_valid&&sin_sof without a handshake: pulse ovf, frame start dropped, remain HOLD.
  - sin_valid without sof: ignored.
- Counter width: clog2(DATA_W+1). No wrap beyond DATA_W.
- dout_ready is ignored outside HOLD.
- abort and ovf are registered single-cycle pulses, never high simultaneously.

Optional Feature:
- Macro XNOR_PARITY_RX_DROP_ERR_EN.
- Defined: frames failing parity never assert dout_valid. The block returns to IDLE the cycle after the parity strobe, dout keeps its previous value, and par_err pulses for one cycle to report the drop.
- Undefined: failing frames are delivered with par_err=1, held with dout_valid as described under Behaviour.

Test Plan:
- DATA_W=8, reset then frame 0xA5 (bits 1,0,1,0,0,1,0,1, p=1), dout_ready=1 -> one cycle after the parity strobe dout=0xA5, dout_valid=1, par_err=0; dout_valid low the next cycle.
- Frame 0x07 with p=1 (wrong; correct p=0) -> dout=0x07, par_err=1 (macro off). With XNOR_PARITY_RX_DROP_ERR_EN: no dout_valid, one-cycle par_err pulse.
- dout_ready=0, frame 0x3C (p=1) received, then new sof -> ovf pulses once, dout stays 0x3C, dout_valid stays 1. Raise dout_ready -> handshake, return to IDLE.
- sof after 4 data bits, then full frame 0xFF (p=1) -> abort pulses once, dout=0xFF, par_err=0.
- dout_ready rises in the same cycle as the next frame's sof -> first word is accepted and the second frame 0x81 (p=1) is received intact.
- rst_n low mid-frame (asynchronous, between clock edges) -> all outputs 0 immediately; the subsequent frame 0x5A (p=1) decodes correctly.
